// File: rtl/fadd_arbiter.sv
// fadd_arbiter
// Shares one single-precision floating-point adder (stb/ack handshake) among
// NREQ requesters. The winner is picked round-robin, its operands are
// latched at grant, and the adder handshake runs to completion. The sum is
// then returned with a one-cycle done pulse. A watchdog resets a hung adder
// and answers the requester with a qNaN and err=1.
//
// Ports
//   CLK, reset               clock (rising edge), asynchronous active-low reset
//   req[NREQ]                request levels
//   req_a/req_b[32*NREQ]     operands, requester i in bits [32i+31:32i]
//   gnt[NREQ]                one-hot grant, grant cycle through done cycle
//   done[NREQ]               one-cycle completion pulse to the winner
//   err, result              valid with done; result held until next done
//   busy                     high whenever the FSM is not IDLE
//   add_a, add_b, add_a_stb, add_b_stb, add_a_ack, add_b_ack
//                            operand side of the adder handshake
//   add_z, add_z_stb, add_z_ack
//                            result side of the adder handshake
//   add_rst                  active-high adder reset
module fadd_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [32*NREQ-1:0]  req_a,
    input  logic [32*NREQ-1:0]  req_b,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic                err,
    output logic [31:0]         result,
    output logic                busy,
    output logic [31:0]         add_a,
    output logic [31:0]         add_b,
    output logic                add_a_stb,
    output logic                add_b_stb,
    input  logic                add_a_ack,
    input  logic                add_b_ack,
    input  logic [31:0]         add_z,
    input  logic                add_z_stb,
    output logic                add_z_ack,
    output logic                add_rst
);

    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [31:0]    QNAN    = 32'h7FC0_0000;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_Z, RESP, RECOVER} state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     ptr_reg, ptr_next;
    logic [NREQ-1:0]   gnt_reg, gnt_next;
    logic [NREQ-1:0]   done_reg, done_next;
    logic              err_reg, err_next;
    logic [31:0]       result_reg, result_next;
    logic [31:0]       add_a_reg, add_a_next;
    logic [31:0]       add_b_reg, add_b_next;
    logic              a_stb_reg, a_stb_next;
    logic              b_stb_reg, b_stb_next;
    logic              z_ack_reg, z_ack_next;
    logic              add_rst_reg, add_rst_next;
    logic [WDW-1:0]    wd_cnt_reg, wd_cnt_next;
    logic              rec_cnt_reg, rec_cnt_next;
    logic              wd_hit;

    // Round-robin search: candidate gi is the requester gi places above ptr
    // (with wrap); the lowest offset with a pending request wins.
    logic [PW-1:0]     cand_idx [NREQ];
    logic [NREQ-1:0]   cand_req;
    logic [PW-1:0]     win_idx;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        logic [PW:0] sum;
        assign sum          = {1'b0, ptr_reg} + (PW+1)'(gi);
        assign cand_idx[gi] = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ))
                                                     : sum[PW-1:0];
        assign cand_req[gi] = req[cand_idx[gi]];
    end

    always_comb begin
        win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                win_idx = cand_idx[k];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        gnt_next     = gnt_reg;
        done_next    = done_reg;
        err_next     = err_reg;
        result_next  = result_reg;
        add_a_next   = add_a_reg;
        add_b_next   = add_b_reg;
        a_stb_next   = a_stb_reg;
        b_stb_next   = b_stb_reg;
        z_ack_next   = z_ack_reg;
        add_rst_next = add_rst_reg;
        wd_cnt_next  = wd_cnt_reg;
        rec_cnt_next = rec_cnt_reg;
        wd_hit       = 1'b0;

        case (state_reg)
            IDLE: begin
                // add_rst is only high here on the first edge after reset
                // release; that edge drops it and is not allowed to grant.
                add_rst_next = 1'b0;
                if (!add_rst_reg && (|req)) begin
                    gnt_next    = NREQ'(1) << win_idx;
                    add_a_next  = req_a[32*int'(win_idx) +: 32];
                    add_b_next  = req_b[32*int'(win_idx) +: 32];
                    a_stb_next  = 1'b1;
                    b_stb_next  = 1'b1;
                    ptr_next    = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    wd_cnt_next = '0;
                    state_next  = LOAD;
                end
            end
            LOAD: begin
                if (a_stb_reg && add_a_ack) a_stb_next = 1'b0;
                if (b_stb_reg && add_b_ack) b_stb_next = 1'b0;
                if (wd_cnt_reg == WD_LAST) begin
                    wd_hit = 1'b1;
                end else begin
                    wd_cnt_next = wd_cnt_reg + 1'b1;
                    if (!a_stb_next && !b_stb_next) state_next = WAIT_Z;
                end
            end
            WAIT_Z: begin
                if (add_z_stb) begin
                    result_next = add_z;
                    z_ack_next  = 1'b1;
                    done_next   = gnt_reg;
                    err_next    = 1'b0;
                    state_next  = RESP;
                end else if (wd_cnt_reg == WD_LAST) begin
                    wd_hit = 1'b1;
                end else begin
                    wd_cnt_next = wd_cnt_reg + 1'b1;
                end
            end
            RECOVER: begin
                // Two cycles of adder reset, then the error answer goes out
                // through RESP like a normal completion.
                if (!rec_cnt_reg) begin
                    rec_cnt_next = 1'b1;
                end else begin
                    add_rst_next = 1'b0;
                    done_next    = gnt_reg;
                    err_next     = 1'b1;
                    result_next  = QNAN;
                    state_next   = RESP;
                end
            end
            RESP: begin
                z_ack_next = 1'b0;
                done_next  = '0;
                gnt_next   = '0;
                err_next   = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (wd_hit) begin
            add_rst_next = 1'b1;
            a_stb_next   = 1'b0;
            b_stb_next   = 1'b0;
            z_ack_next   = 1'b0;
            rec_cnt_next = 1'b0;
            state_next   = RECOVER;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            gnt_reg     <= '0;
            done_reg    <= '0;
            err_reg     <= 1'b0;
            result_reg  <= '0;
            add_a_reg   <= '0;
            add_b_reg   <= '0;
            a_stb_reg   <= 1'b0;
            b_stb_reg   <= 1'b0;
            z_ack_reg   <= 1'b0;
            add_rst_reg <= 1'b1;
            wd_cnt_reg  <= '0;
            rec_cnt_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            gnt_reg     <= gnt_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            result_reg  <= result_next;
            add_a_reg   <= add_a_next;
            add_b_reg   <= add_b_next;
            a_stb_reg   <= a_stb_next;
            b_stb_reg   <= b_stb_next;
            z_ack_reg   <= z_ack_next;
            add_rst_reg <= add_rst_next;
            wd_cnt_reg  <= wd_cnt_next;
            rec_cnt_reg <= rec_cnt_next;
        end
    end

    assign gnt       = gnt_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign result    = result_reg;
    assign busy      = (state_reg != IDLE);
    assign add_a     = add_a_reg;
    assign add_b     = add_b_reg;
    assign add_a_stb = a_stb_reg;
    assign add_b_stb = b_stb_reg;
    assign add_z_ack = z_ack_reg;
    assign add_rst   = add_rst_reg;

endmodule

// File: tb/tb_fadd_arbiter.sv
// Bench for fadd_arbiter: table of arbitration vectors plus hand-written
// sequences for unequal acks, dropped request, hung adder and mid-op reset.
module tb_fadd_arbiter;

    logic         CLK;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] req_a, req_b;
    logic [3:0]   gnt, done;
    logic         err, busy;
    logic [31:0]  result, add_a, add_b, add_z;
    logic         add_a_stb, add_b_stb, add_a_ack, add_b_ack;
    logic         add_z_stb, add_z_ack, add_rst;

    fadd_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
        .CLK(CLK), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .done(done), .err(err), .result(result), .busy(busy),
        .add_a(add_a), .add_b(add_b), .add_a_stb(add_a_stb), .add_b_stb(add_b_stb),
        .add_a_ack(add_a_ack), .add_b_ack(add_b_ack), .add_z(add_z),
        .add_z_stb(add_z_stb), .add_z_ack(add_z_ack), .add_rst(add_rst)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("ok   %s: %h", name, act);
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total_cnt++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // ---------------- adder model (hand-computed sums) ----------------
    int ack_a_dly = 0;
    int ack_b_dly = 0;
    bit hang      = 1'b0;

    function automatic logic [31:0] fsum(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h3F800000}: fsum = 32'h40000000; // 1+1
            {32'h40000000, 32'h40000000}: fsum = 32'h40800000; // 2+2
            {32'h3F800000, 32'h40000000}: fsum = 32'h40400000; // 1+2
            {32'h41200000, 32'h40C00000}: fsum = 32'h41800000; // 10+6
            {32'hBF800000, 32'h3F800000}: fsum = 32'h00000000; // -1+1
            {32'h3FC00000, 32'h3F000000}: fsum = 32'h40000000; // 1.5+0.5
            default:                      fsum = 32'hDEADBEEF;
        endcase
    endfunction

    initial begin
        int ca, cb;
        bit got_a, got_b;
        logic [31:0] cap_a, cap_b;
        add_a_ack = 0; add_b_ack = 0; add_z_stb = 0; add_z = '0;
        ca = 0; cb = 0; got_a = 0; got_b = 0; cap_a = '0; cap_b = '0;
        forever begin
            @(negedge CLK);
            add_a_ack = 0;
            add_b_ack = 0;
            if (!reset || add_rst) begin
                add_z_stb = 0; ca = 0; cb = 0; got_a = 0; got_b = 0;
            end else if (add_z_stb && add_z_ack) begin
                add_z_stb = 0; ca = 0; cb = 0; got_a = 0; got_b = 0;
            end else begin
                if (add_a_stb && !got_a) begin
                    if (ca >= ack_a_dly) begin add_a_ack = 1; got_a = 1; cap_a = add_a; end
                    else ca++;
                end
                if (add_b_stb && !got_b) begin
                    if (cb >= ack_b_dly) begin add_b_ack = 1; got_b = 1; cap_b = add_b; end
                    else cb++;
                end
                if (got_a && got_b && !add_a_ack && !add_b_ack && !add_z_stb && !hang) begin
                    add_z_stb = 1;
                    add_z     = fsum(cap_a, cap_b);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_gnt(input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (gnt != 0) begin ok = 1; break; end
        end
        if (!ok) timeout_fail({name, " gnt"});
    endtask

    task automatic run_op(input string name, input logic [3:0] r, input logic [127:0] a,
                          input logic [127:0] b, input logic [3:0] eg,
                          input logic [31:0] er, input bit drop);
        bit ok;
        int lat, idx;
        req = r; req_a = a; req_b = b;
        wait_gnt(name, ok);
        if (!ok) return;
        check({name, " gnt"}, 32'(gnt), 32'(eg));
        idx = 0;
        for (int i = 0; i < 4; i++) if (eg[i]) idx = i;
        check({name, " add_a"}, add_a, a[32*idx +: 32]);
        check({name, " add_b"}, add_b, b[32*idx +: 32]);
        if (drop) req = '0;
        req_a = ~a; req_b = ~b;
        lat = 0; ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (done != 0) begin ok = 1; break; end
            @(negedge CLK);
            lat++;
        end
        if (!ok) begin timeout_fail({name, " done"}); return; end
        check({name, " done"}, 32'(done), 32'(eg));
        check({name, " result"}, result, er);
        check({name, " err"}, 32'(err), 32'd0);
        check({name, " latency"}, 32'(lat), 32'd2);
        @(negedge CLK);
        check({name, " done_pulse"}, 32'(done), 32'd0);
    endtask

    typedef struct {
        logic [3:0]   r;
        logic [127:0] a;
        logic [127:0] b;
        logic [3:0]   eg;
        logic [31:0]  er;
    } vec_t;

    vec_t vecs[11];

    localparam logic [127:0] A0 = {32'h41200000, 32'h3F800000, 32'h40000000, 32'h3F800000};
    localparam logic [127:0] B0 = {32'h40C00000, 32'h40000000, 32'h40000000, 32'h3F800000};
    localparam logic [127:0] A1 = {32'h3FC00000, 32'hBF800000, 32'h40000000, 32'h3F800000};
    localparam logic [127:0] B1 = {32'h3F000000, 32'h3F800000, 32'h40000000, 32'h3F800000};

    initial begin
        #200000;
        $display("FAIL global: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bit ok;
        int b_fall, a_fall, rst_cyc, bad_hs;
        vecs[0]  = '{4'b1111, A0, B0, 4'b0001, 32'h40000000};
        vecs[1]  = '{4'b1111, A0, B0, 4'b0010, 32'h40800000};
        vecs[2]  = '{4'b1111, A0, B0, 4'b0100, 32'h40400000};
        vecs[3]  = '{4'b1111, A0, B0, 4'b1000, 32'h41800000};
        vecs[4]  = '{4'b1111, A0, B0, 4'b0001, 32'h40000000};
        vecs[5]  = '{4'b0100, A0, B0, 4'b0100, 32'h40400000};
        vecs[6]  = '{4'b0011, A0, B0, 4'b0001, 32'h40000000};
        vecs[7]  = '{4'b1001, A0, B0, 4'b1000, 32'h41800000};
        vecs[8]  = '{4'b0110, A1, B1, 4'b0010, 32'h40800000};
        vecs[9]  = '{4'b0100, A1, B1, 4'b0100, 32'h00000000};
        vecs[10] = '{4'b1000, A1, B1, 4'b1000, 32'h40000000};

        reset = 0; req = '0; req_a = '0; req_b = '0;
        repeat (3) @(negedge CLK);
        check("rst gnt", 32'(gnt), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst add_rst", 32'(add_rst), 32'd1);
        check("rst stb", 32'({add_a_stb, add_b_stb, add_z_ack}), 32'd0);
        check("rst result", result, 32'd0);
        reset = 1;
        @(negedge CLK);
        check("rel add_rst", 32'(add_rst), 32'd0);

        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), vecs[i].r, vecs[i].a, vecs[i].b,
                   vecs[i].eg, vecs[i].er, 1'b0);

        // Unequal acks: b acks 3 cycles before a (ptr = 0).
        ack_a_dly = 3; ack_b_dly = 0;
        req = 4'b0001; req_a = A0; req_b = B0;
        wait_gnt("uneq", ok);
        req = '0;
        b_fall = -1; a_fall = -1; ok = 0;
        for (int c = 0; c < 30; c++) begin
            if (!add_b_stb && b_fall < 0) b_fall = c;
            if (!add_a_stb && a_fall < 0) a_fall = c;
            if (done != 0) begin ok = 1; break; end
            @(negedge CLK);
        end
        if (!ok) timeout_fail("uneq done");
        check("uneq a_after_b", 32'(a_fall - b_fall), 32'd3);
        check("uneq result", result, 32'h40000000);
        check("uneq done", 32'(done), 32'b0001);
        @(negedge CLK);
        ack_a_dly = 0;

        // Drop req after grant; ptr still advances (1 -> 2).
        run_op("drop", 4'b0010, A0, B0, 4'b0010, 32'h40800000, 1'b1);
        run_op("after_drop", 4'b0110, A0, B0, 4'b0100, 32'h40400000, 1'b0);

        // Hung adder: watchdog recovery (ptr = 3, so requester 0 wins).
        hang = 1;
        req = 4'b0001; req_a = A0; req_b = B0;
        wait_gnt("hang", ok);
        check("hang gnt", 32'(gnt), 32'b0001);
        req = '0;
        ok = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            if (add_rst) begin ok = 1; break; end
        end
        if (!ok) timeout_fail("hang add_rst");
        rst_cyc = 0; bad_hs = 0;
        while (add_rst && rst_cyc < 10) begin
            if (add_a_stb || add_b_stb || add_z_ack || done != 0) bad_hs++;
            rst_cyc++;
            @(negedge CLK);
        end
        check("hang rst_cycles", 32'(rst_cyc), 32'd2);
        check("hang quiet_hs", 32'(bad_hs), 32'd0);
        check("hang done", 32'(done), 32'b0001);
        check("hang err", 32'(err), 32'd1);
        check("hang result", result, 32'h7FC00000);
        @(negedge CLK);
        check("hang done_pulse", 32'(done), 32'd0);
        hang = 0;
        run_op("post_recover", 4'b0010, A0, B0, 4'b0010, 32'h40800000, 1'b0);

        // Reset during WAIT_Z (ptr = 2).
        hang = 1;
        req = 4'b0100; req_a = A0; req_b = B0;
        wait_gnt("midrst", ok);
        req = '0;
        repeat (4) @(negedge CLK);
        check("midrst in_wait", 32'({busy, add_a_stb, add_b_stb}), 32'b100);
        reset = 0;
        #1;
        check("midrst gnt", 32'(gnt), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst add_rst", 32'(add_rst), 32'd1);
        check("midrst result", result, 32'd0);
        check("midrst add_a", add_a, 32'd0);
        @(negedge CLK);
        hang = 0;
        req = 4'b0001; req_a = A0; req_b = B0;
        reset = 1;
        @(negedge CLK);
        check("midrst edge1 add_rst", 32'(add_rst), 32'd0);
        check("midrst edge1 gnt", 32'({gnt, done}), 32'd0);
        @(negedge CLK);
        check("midrst edge2 gnt", 32'(gnt), 32'b0001);
        req = '0;
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            if (done != 0) begin ok = 1; break; end
            @(negedge CLK);
        end
        if (!ok) timeout_fail("midrst done");
        check("midrst done", 32'(done), 32'b0001);
        check("midrst new_result", result, 32'h40000000);
        @(negedge CLK);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
